// File: rtl/mul_pkg.sv
// Shared constants and state type for the 16x16 sequential multiplier and
// the blocks that drive it.
package mul_pkg;

    localparam int MUL_WIDTH   = 16;
    localparam int MUL_LATENCY = 17;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } mul_state_t;

endpackage

// File: rtl/mul_cycle_counter.sv
// Cycle counter for the multiplier run: synchronous clear, count enable and
// a terminal flag raised while the count sits at LATENCY-1.
module mul_cycle_counter
    import mul_pkg::*;
#(
    parameter int LATENCY = MUL_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = $clog2(LATENCY) + 1;

    logic [CW-1:0] count;

    // Cleared before every run, so the count never reaches its wrap point.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == CW'(LATENCY - 1));

endmodule

// File: rtl/multiplier_driver.sv
// Control stage for the sequential multiplier: accepts an operand pair, runs
// the multiplier for its fixed latency, and holds the product for downstream.
module multiplier_driver #(
    parameter int WIDTH       = mul_pkg::MUL_WIDTH,
    parameter int MUL_LATENCY = mul_pkg::MUL_LATENCY
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               mul_rst,
    output logic [WIDTH-1:0]   mul_num1,
    output logic [WIDTH-1:0]   mul_num2,
    input  logic [2*WIDTH-1:0] mul_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic               busy
);

    import mul_pkg::*;

    mul_state_t state;
    mul_state_t state_next;
    logic       accept;
    logic       count_clear;
    logic       count_enable;
    logic       capture;
    logic       terminal;

    mul_cycle_counter #(
        .LATENCY (MUL_LATENCY)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (count_clear),
        .enable   (count_enable),
        .terminal (terminal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        count_clear  = 1'b0;
        count_enable = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                count_clear = 1'b1;
                state_next  = RUN;
            end
            RUN: begin
                count_enable = 1'b1;
                if (terminal) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake and multiplier control come only from the registered state.
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign mul_rst   = (state == RUN) || (state == DONE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_num1   <= '0;
            mul_num2   <= '0;
            out_result <= '0;
        end else begin
            if (accept) begin
                mul_num1 <= in_a;
                mul_num2 <= in_b;
            end
            if (capture) begin
                out_result <= mul_result;
            end
        end
    end

endmodule

// File: tb/tb_multiplier_driver.sv
// Self-checking bench for multiplier_driver: a behavioural multiplier stand-in,
// a timeline reference model, directed cases and a randomized run.
module tb_multiplier_driver;

    import mul_pkg::*;

    localparam int W   = MUL_WIDTH;
    localparam int LAT = MUL_LATENCY;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           mul_rst;
    logic [W-1:0]   mul_num1;
    logic [W-1:0]   mul_num2;
    logic [2*W-1:0] mul_result;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_result;
    logic           busy;

    int vectors;
    int miscompares;
    int cyc;

    multiplier_driver #(
        .WIDTH       (W),
        .MUL_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mul_rst    (mul_rst),
        .mul_num1   (mul_num1),
        .mul_num2   (mul_num2),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stand-in: the product is only final LAT-1 counted cycles after
    // release from reset; before that the output is noise.
    int             mcnt;
    logic [2*W-1:0] noise;

    always @(posedge clk) begin
        noise <= $urandom;
        if (!mul_rst) begin
            mcnt <= 0;
        end else if (mcnt < 100000) begin
            mcnt <= mcnt + 1;
        end
    end

    assign mul_result = (mcnt >= LAT - 1) ? (32'(mul_num1) * 32'(mul_num2)) : noise;

    // Reference timeline: a job is 'age' cycles past its accept edge; the
    // product is due from age LAT+2 until the output handshake.
    logic           job;
    int             age;
    logic [W-1:0]   m_a;
    logic [W-1:0]   m_b;
    logic [2*W-1:0] m_res;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            job   <= 1'b0;
            age   <= 0;
            m_a   <= '0;
            m_b   <= '0;
            m_res <= '0;
        end else if (!job) begin
            if (in_valid) begin
                job <= 1'b1;
                age <= 1;
                m_a <= in_a;
                m_b <= in_b;
            end
        end else if (age >= LAT + 2) begin
            if (out_ready) job <= 1'b0;
        end else begin
            age <= age + 1;
            if (age + 1 == LAT + 2) m_res <= 32'(m_a) * 32'(m_b);
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, want 0x%08h",
                     name, cyc, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a pair and hold it until the accept edge; returns that cycle index.
    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input bit keep, output int acc);
        int guard;
        guard    = 0;
        acc      = -1;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: in_ready got 0, want 1 within 300 cycles");
            in_valid = 1'b0;
        end else begin
            tick();
            acc = cyc;
            if (!keep) in_valid = 1'b0;
        end
    endtask

    // Run one job with out_ready high; report latency from accept edge and product.
    task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat, output logic [2*W-1:0] res);
        int acc;
        out_ready = 1'b1;
        apply_stimulus(a, b, 1'b0, acc);
        lat = 1;
        while (!out_valid && lat < 80) begin
            tick();
            lat++;
        end
        res = out_result;
        tick();
    endtask

    initial begin
        int             lat;
        int             acc;
        int             accs[3];
        logic [2*W-1:0] res;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        int             guard;

        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        out_ready   = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (rst) begin
                    check_output("in_ready",   32'(in_ready),  32'(!job));
                    check_output("busy",       32'(busy),      32'(job));
                    check_output("mul_rst",    32'(mul_rst),   32'(job && age >= 2));
                    check_output("out_valid",  32'(out_valid), 32'(job && age >= LAT + 2));
                    check_output("out_result", out_result,     m_res);
                    check_output("mul_num1",   32'(mul_num1),  32'(m_a));
                    check_output("mul_num2",   32'(mul_num2),  32'(m_b));
                end
            end
        join_none

        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_output("rst_in_ready",   32'(in_ready),  32'h1);
        check_output("rst_out_valid",  32'(out_valid), 32'h0);
        check_output("rst_mul_rst",    32'(mul_rst),   32'h0);
        check_output("rst_out_result", out_result,     32'h0000_0000);

        run_job(16'h1234, 16'h0003, lat, res);
        check_output("lat_1234x3", 32'(lat), 32'd19);
        check_output("res_1234x3", res,      32'h0000_369C);
        check_output("in_ready_after_hs", 32'(in_ready), 32'h1);

        run_job(16'hFFFF, 16'hFFFF, lat, res);
        check_output("lat_ffffxffff", 32'(lat), 32'd19);
        check_output("res_ffffxffff", res,      32'hFFFE_0001);
        run_job(16'h0000, 16'hABCD, lat, res);
        check_output("lat_0xabcd", 32'(lat), 32'd19);
        check_output("res_0xabcd", res,      32'h0000_0000);

        // Backpressure with a second pair offered while the product waits.
        out_ready = 1'b0;
        apply_stimulus(16'h1234, 16'h0003, 1'b0, acc);
        lat = 1;
        while (!out_valid && lat < 80) begin
            tick();
            lat++;
        end
        check_output("lat_backpressure", 32'(lat), 32'd19);
        in_a     = 16'h0007;
        in_b     = 16'h0009;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_output("bp_out_valid",  32'(out_valid), 32'h1);
            check_output("bp_out_result", out_result,     32'h0000_369C);
            check_output("bp_in_ready",   32'(in_ready),  32'h0);
            tick();
        end
        out_ready = 1'b1;
        apply_stimulus(16'h0007, 16'h0009, 1'b0, acc);
        lat = 1;
        while (!out_valid && lat < 80) begin
            tick();
            lat++;
        end
        check_output("res_7x9", out_result, 32'h0000_003F);
        tick();

        // Reset five cycles into RUN.
        apply_stimulus(16'h1234, 16'h0005, 1'b0, acc);
        repeat (6) tick();
        #3 rst = 1'b0;
        #1;
        check_output("mid_rst_out_valid",  32'(out_valid), 32'h0);
        check_output("mid_rst_mul_rst",    32'(mul_rst),   32'h0);
        check_output("mid_rst_in_ready",   32'(in_ready),  32'h1);
        check_output("mid_rst_busy",       32'(busy),      32'h0);
        check_output("mid_rst_out_result", out_result,     32'h0000_0000);
        check_output("mid_rst_mul_num1",   32'(mul_num1),  32'h0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (25) tick();
        run_job(16'h0010, 16'h0010, lat, res);
        check_output("res_10x10", res, 32'h0000_0100);
        check_output("lat_10x10", 32'(lat), 32'd19);

        // Three queued pairs, in_valid held high throughout.
        out_ready = 1'b1;
        apply_stimulus(16'h0002, 16'h0003, 1'b1, accs[0]);
        apply_stimulus(16'h0100, 16'h0100, 1'b1, accs[1]);
        apply_stimulus(16'hFFFF, 16'h0002, 1'b0, accs[2]);
        check_output("b2b_gap_1", 32'(accs[1] - accs[0]), 32'(LAT + 3));
        check_output("b2b_gap_2", 32'(accs[2] - accs[1]), 32'(LAT + 3));
        guard = 0;
        while (busy && guard < 100) begin
            tick();
            guard++;
        end
        check_output("b2b_last_res", out_result, 32'h0001_FFFE);

        // Randomized jobs with random gaps and random output backpressure.
        for (int j = 0; j < 25; j++) begin
            case ($urandom_range(0, 5))
                0:       begin ra = 16'h0000;              rb = 16'($urandom); end
                1:       begin ra = 16'hFFFF;              rb = 16'hFFFF;      end
                default: begin ra = 16'($urandom);         rb = 16'($urandom); end
            endcase
            repeat ($urandom_range(0, 3)) tick();
            out_ready = 1'($urandom_range(0, 1));
            apply_stimulus(ra, rb, 1'b0, acc);
            guard = 0;
            while (busy && guard < 300) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
                guard++;
            end
            if (busy) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL random_job_timeout: busy got 1, want 0 within 300 cycles");
            end
        end

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
